// File: rtl/fifo_modport.sv
`default_nettype none
// ============================================================================
// Module      : fifo_modport
// Description : Single-clock synchronous FIFO backing the fifo_intf bundle.
//               Write port (winc/wdata/wfull) and read port
//               (rinc/rdata/rempty) share wclk. Flags are decoded from
//               registered ASIZE+1 bit pointers (MSB is the wrap bit).
//               Optional FIFO_ASSERT_EN compiles in protocol/flag checks.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_modport #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
);

    localparam int             c_DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] c_PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    logic [DSIZE-1:0] r_mem [c_DEPTH];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [DSIZE-1:0] r_rdata;

    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_full;
    logic             w_empty;

    // Flags depend only on registered pointers, so they never follow winc/rinc.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                     (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);

    // Requests against a blocking flag are dropped without side effects.
    assign w_wr_en = winc && !w_full;
    assign w_rd_en = rinc && !w_empty;

    assign wfull  = w_full;
    assign rempty = w_empty;
    assign rdata  = r_rdata;

    // Storage array; contents survive reset, pointers make stale words unreachable.
    always_ff @(posedge wclk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[ASIZE-1:0]] <= wdata;
        end
    end

    // Write pointer; wraps naturally modulo 2**(ASIZE+1).
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wptr <= '0;
        end else if (w_wr_en) begin
            r_wptr <= r_wptr + c_PTR_ONE;
        end
    end

    // Read pointer and registered read data; rdata holds when no read is accepted.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_rptr  <= '0;
            r_rdata <= '0;
        end else if (w_rd_en) begin
            r_rptr  <= r_rptr + c_PTR_ONE;
            r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
        end
    end

`ifdef FIFO_ASSERT_EN
    // Inputs must be known whenever the block is out of reset.
    a_inputs_known : assert property (@(posedge wclk) disable iff (!wrst_n)
        !$isunknown({winc, wdata, rinc}))
        else $error("fifo_modport: X/Z on winc/wdata/rinc");

    // Reset must force the empty, not-full state.
    a_reset_flags : assert property (@(posedge wclk)
        !wrst_n |-> (rempty && !wfull))
        else $error("fifo_modport: flags wrong during reset");

    // Full and empty are mutually exclusive.
    a_flags_exclusive : assert property (@(posedge wclk)
        !(wfull && rempty))
        else $error("fifo_modport: wfull and rempty both set");

    // No accepted write while full.
    a_no_write_full : assert property (@(posedge wclk) disable iff (!wrst_n)
        !(w_wr_en && wfull))
        else $error("fifo_modport: write accepted while full");

    // No accepted read while empty.
    a_no_read_empty : assert property (@(posedge wclk) disable iff (!wrst_n)
        !(w_rd_en && rempty))
        else $error("fifo_modport: read accepted while empty");
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_modport.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_modport
// Description : Directed, self-checking bench for fifo_modport. A queue holds
//               the words the FIFO should contain; reads pop the expected
//               rdata, and flags are predicted from the queue occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_modport;

    localparam int DSIZE   = 8;
    localparam int ASIZE   = 4;
    localparam int c_DEPTH = 1 << ASIZE;

    logic             wclk;
    logic             wrst_n;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;

    int               n_tests;
    int               n_fail;
    logic [DSIZE-1:0] sb_q [$];
    logic [DSIZE-1:0] exp_rdata;

    fifo_modport #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict, check after the rising edge.
    task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r, input string tag);
        logic acc_w;
        logic acc_r;
        @(negedge wclk);
        winc  = w;
        wdata = d;
        rinc  = r;
        #1;
        check({tag, "/pre_rempty"}, 32'(rempty), 32'(sb_q.size() == 0));
        check({tag, "/pre_wfull"},  32'(wfull),  32'(sb_q.size() == c_DEPTH));
        acc_r = r && (sb_q.size() != 0);
        acc_w = w && (sb_q.size() != c_DEPTH);
        if (acc_r) exp_rdata = sb_q.pop_front();
        if (acc_w) sb_q.push_back(d);
        @(posedge wclk);
        #1;
        check({tag, "/rdata"},  32'(rdata),  32'(exp_rdata));
        check({tag, "/rempty"}, 32'(rempty), 32'(sb_q.size() == 0));
        check({tag, "/wfull"},  32'(wfull),  32'(sb_q.size() == c_DEPTH));
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_rdata = '0;
        winc      = 1'b0;
        rinc      = 1'b0;
        wdata     = '0;
        wrst_n    = 1'b1;
        #1 wrst_n = 1'b0;
        #1;
        check("reset/rempty", 32'(rempty), 32'd1);
        check("reset/wfull",  32'(wfull),  32'd0);
        check("reset/rdata",  32'(rdata),  32'd0);
        // Requests during reset must not take effect.
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'hEE;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        check("reset_hold/rempty", 32'(rempty), 32'd1);
        check("reset_hold/wfull",  32'(wfull),  32'd0);
        check("reset_hold/rdata",  32'(rdata),  32'd0);
        winc = 1'b0;
        rinc = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;

        // Mid-stream reset after three writes and one read.
        step(1'b1, 8'h11, 1'b0, "pre_rst_w0");
        step(1'b1, 8'h22, 1'b0, "pre_rst_w1");
        step(1'b1, 8'h33, 1'b0, "pre_rst_w2");
        step(1'b0, 8'h00, 1'b1, "pre_rst_r0");
        #2 wrst_n = 1'b0;
        #1;
        check("midrst/rempty", 32'(rempty), 32'd1);
        check("midrst/wfull",  32'(wfull),  32'd0);
        check("midrst/rdata",  32'(rdata),  32'd0);
        sb_q.delete();
        exp_rdata = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, "post_rst_read");
        step(1'b1, 8'h44, 1'b0, "post_rst_w");
        step(1'b0, 8'h00, 1'b1, "post_rst_r");

        // Fill to full, then an ignored overflow write.
        for (int i = 0; i < c_DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, "fill");
        end
        check("fill/wfull_after_16", 32'(wfull), 32'd1);
        step(1'b1, 8'hAA, 1'b0, "overflow");

        // Simultaneous request on full: only the read is accepted.
        step(1'b1, 8'h55, 1'b1, "simul_full");
        check("simul_full/rdata00", 32'(rdata), 32'h00);

        // Drain the remaining 15 words.
        for (int i = 1; i < c_DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, "drain");
        end
        check("drain/rempty", 32'(rempty), 32'd1);

        // Underflow leaves rdata at the last word.
        step(1'b0, 8'h00, 1'b1, "underflow");
        check("underflow/rdata0F", 32'(rdata), 32'h0F);

        // Simultaneous request on empty: only the write is accepted.
        step(1'b1, 8'h33, 1'b1, "simul_empty");
        step(1'b0, 8'h00, 1'b1, "simul_empty_rd");
        check("simul_empty/rdata33", 32'(rdata), 32'h33);

        // Interleaved write/read pairs; pointers pass through the 31->0 wrap.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0, "wrap_w");
            step(1'b0, 8'h00, 1'b1, "wrap_r");
        end
        // Concurrent streaming with a few words in flight.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'hC0 + i), 1'b0, "stream_pre");
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 8'(8'hD0 + i), 1'b1, "stream");
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, "stream_drain");
        end
        check("final/rempty", 32'(rempty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
